// File: rtl/cla_pkg.sv
// Shared definitions for the sliced carry-lookahead adder: sequencer state
// encoding and the slice-index width helper.
package cla_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bits needed to index n slices; never narrower than one bit so CHUNKS=1 still has an index.
    function automatic int idx_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cla_adder.sv
// Single-level carry-lookahead adder: every carry is a flat sum of
// generate/propagate products, so depth does not grow as a ripple chain.
module cla_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_c;
    logic             w_cv;
    logic             w_tv;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded per bit.
    always_comb begin
        w_c    = '0;
        w_cv   = 1'b0;
        w_tv   = 1'b0;
        w_c[0] = i_cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_cv = i_cin;
            for (int j = 0; j <= i; j++) begin
                w_cv = w_cv & w_p[j];
            end
            for (int k = 0; k <= i; k++) begin
                w_tv = w_g[k];
                for (int j = k + 1; j <= i; j++) begin
                    w_tv = w_tv & w_p[j];
                end
                w_cv = w_cv | w_tv;
            end
            w_c[i+1] = w_cv;
        end
    end

    assign o_sum  = w_p ^ w_c[WIDTH-1:0];
    assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/cla_seq_wide_adder.sv
// Wide adder/subtractor that feeds CHUNK-bit slices of the operands through
// one shared cla_adder, LSB slice first, one slice per clock.
module cla_seq_wide_adder
    import cla_pkg::*;
#(
    parameter int CHUNK  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sub,
    input  logic                      cin,
    input  logic [CHUNK*CHUNKS-1:0]   a,
    input  logic [CHUNK*CHUNKS-1:0]   b,
    output logic                      busy,
    output logic                      done,
    output logic [CHUNK*CHUNKS-1:0]   sum,
    output logic                      cout,
    output logic                      ovf
);

    localparam int TOTAL = CHUNK * CHUNKS;
    localparam int IDX_W = idx_width(CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    state_t             r_state;
    logic [TOTAL-1:0]   r_a;
    logic [TOTAL-1:0]   r_b;
    logic [TOTAL-1:0]   r_acc;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;

    logic [CHUNK-1:0]   w_slice_sum;
    logic               w_slice_cout;
    logic [TOTAL-1:0]   w_acc_next;

    cla_adder #(.WIDTH(CHUNK)) u_cla (
        .i_a    (r_a[int'(r_idx)*CHUNK +: CHUNK]),
        .i_b    (r_b[int'(r_idx)*CHUNK +: CHUNK]),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    // Accumulator with the current slice merged in; on the last slice this is the full result.
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[int'(r_idx)*CHUNK +: CHUNK] = w_slice_sum;
    end

    // Sequencer: capture operands on start, walk the slices, publish the result on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_slice_cout;
                    if (r_idx == LAST_IDX) begin
                        sum     <= w_acc_next;
                        cout    <= w_slice_cout;
                        ovf     <= (r_a[TOTAL-1] == r_b[TOTAL-1]) &
                                   (w_acc_next[TOTAL-1] != r_a[TOTAL-1]);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
